instr_encoder_loader: RTL
=========================

// Module: instr_encoder_loader
// PURPOSE
//  Encoder/write side of the control decoder: takes instruction requests (kind + fields) over valid/ready,
//  packs each into a 32-bit word in the processor format, buffers it in a small FIFO, and streams it into
//  instruction memory at consecutive addresses. Used by the bench/boot path to load programs before run.
//  Opcodes emitted decode to: R=00000, ADDI=00101, SW=00111, LW=01000.
// PARAMETERS
//  FIFO_AW    2   log2 FIFO depth (depth 4)
//  IMEM_AW   12   instruction memory address width
//  BASE_ADDR  0   first imem word address written after start
// PORTS
//  clock       in   1        rising-edge clock
//  reset       in   1        asynchronous, active-low reset
//  start       in   1        pulse: begin load session at BASE_ADDR
//  finish      in   1        pulse: no more requests; complete after FIFO drains
//  in_valid    in   1        request valid
//  in_ready    out  1        request accepted when in_valid & in_ready
//  in_kind     in   2        0=R, 1=ADDI, 2=LW, 3=SW
//  in_rd/rs/rt in   5 each   register fields
//  in_shamt    in   5        R-type shift amount
//  in_aluop    in   5        R-type ALU op
//  in_imm      in   17       I-type immediate
//  imem_we     out  1        write strobe
//  imem_wready in   1        memory accepts write this cycle
//  imem_addr   out  IMEM_AW  write address
//  imem_wdata  out  32       encoded word
//  busy        out  1        state == LOAD
//  done        out  1        session completed cleanly
//  err         out  1        address overflow; sticky until start
//  count       out  IMEM_AW+1 words written this session
// BEHAVIOUR
//  Encoding: R = {00000, rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2], 2'b00};
//   I-type = {op, rd[26:22], rs[21:17], imm[16:0]}. Encoding is registered into FIFO on accept.
//  States: IDLE -> LOAD on start. LOAD -> DONE when finish seen (latched) and FIFO empty.
//   LOAD -> ERR when a write would target address > 2^IMEM_AW-1. DONE/ERR -> LOAD on start.
//  start in LOAD ignored. start in DONE/ERR: clears count, done, err, finish latch, FIFO; addr=BASE_ADDR.
//  in_ready = (state==LOAD) & ~fifo_full & ~finish_latched. Full FIFO: in_ready=0 even if popping same cycle.
//  Push and pop in same cycle (not full, not empty): occupancy unchanged, order preserved.
//  Drain: imem_we = (state==LOAD) & ~fifo_empty; imem_wdata = FIFO head; imem_addr = addr counter.
//   Transfer when imem_we & imem_wready: pop, addr+1, count+1. imem_we/data/addr hold stable while stalled.
//  Latency: accepted request appears on imem_wdata at earliest next cycle (FIFO was empty).
//  Overflow: after writing addr 2^IMEM_AW-1, counter does not wrap; if FIFO non-empty or further
//   requests arrive -> ERR, FIFO flushed, err=1, imem_we=0. Last word exactly at top with finish -> DONE.
//  finish and final pop in same cycle -> DONE next cycle. finish in IDLE ignored.
//  Reset (any time, async): state=IDLE, FIFO empty, addr=BASE_ADDR, count=0; in_ready, imem_we, busy,
//   done, err = 0; imem_wdata=0. In-flight words are discarded; no partial write on next edge.
// TESTING
//  T1 start; ADDI rd=1 rs=0 imm=5, wready=1 -> one write addr 0, data 0x28400005; finish -> done=1, count=1.
//  T2 LW rd=2 rs=1 imm=4, SW rd=2 rs=1 imm=8, R rd=3 rs=1 rt=2 -> writes 0x40820004@0, 0x38820008@1, 0x00C22000@2.
//  T3 wready=0 for 10 cycles, 6 requests -> in_ready drops after 4 accepted; imem signals stable; release -> 6 writes in order.
//  T4 IMEM_AW=2, push 5 words -> addrs 0..3 written, then err=1, busy=0, in_ready=0; start -> err clears, addr 0.
//  T5 assert reset mid-drain with 3 words queued -> next cycle imem_we=0, count=0, state IDLE; no further writes.
//  T6 finish same cycle as last pop; start during LOAD -> DONE next cycle; start ignored, addr unchanged.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Packs instruction requests into 32-bit processor words, queues them in a small FIFO
// and streams them into instruction memory at consecutive addresses for program load.
module instr_encoder_loader #(
   parameter int FIFO_AW   = 2,
   parameter int IMEM_AW   = 12,
   parameter int BASE_ADDR = 0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               finish,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_kind,
   input  logic [4:0]         in_rd,
   input  logic [4:0]         in_rs,
   input  logic [4:0]         in_rt,
   input  logic [4:0]         in_shamt,
   input  logic [4:0]         in_aluop,
   input  logic [16:0]        in_imm,
   output logic               imem_we,
   input  logic               imem_wready,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [31:0]        imem_wdata,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [IMEM_AW:0]   count
);

   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   function automatic logic [31:0] encode(input logic [1:0]  kind,
                                          input logic [4:0]  rd,
                                          input logic [4:0]  rs,
                                          input logic [4:0]  rt,
                                          input logic [4:0]  shamt,
                                          input logic [4:0]  aluop,
                                          input logic [16:0] imm);
      case (kind)
         2'd0:    encode = {5'b00000, rd, rs, rt, shamt, aluop, 2'b00};
         2'd1:    encode = {5'b00101, rd, rs, imm};
         2'd2:    encode = {5'b01000, rd, rs, imm};
         2'd3:    encode = {5'b00111, rd, rs, imm};
         default: encode = 32'd0;
      endcase
   endfunction

   state_t             state_q, state_d;
   logic [IMEM_AW:0]   addr_q, addr_d;
   logic [IMEM_AW:0]   count_q, count_d;
   logic               fin_q, fin_d;
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   occ_q, occ_d;
   logic [31:0]        mem_q [DEPTH];
   logic [31:0]        mem_d [DEPTH];

   logic empty_s, full_s, ovf_s, ready_s, we_s, push_s, pop_s;

   // The extra address bit marks "top word already written" so the counter never wraps.
   assign empty_s = (occ_q == '0);
   assign full_s  = (occ_q == (FIFO_AW+1)'(DEPTH));
   assign ovf_s   = addr_q[IMEM_AW];
   assign ready_s = (state_q == S_LOAD) & ~full_s & ~fin_q;
   assign we_s    = (state_q == S_LOAD) & ~empty_s & ~ovf_s;
   assign push_s  = in_valid & ready_s;
   assign pop_s   = we_s & imem_wready;

   assign in_ready   = ready_s;
   assign imem_we    = we_s;
   assign imem_addr  = addr_q[IMEM_AW-1:0];
   assign imem_wdata = mem_q[rd_ptr_q];
   assign busy       = (state_q == S_LOAD);
   assign done       = (state_q == S_DONE);
   assign err        = (state_q == S_ERR);
   assign count      = count_q;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      count_d  = count_q;
      fin_d    = fin_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      mem_d    = mem_q;
      case (state_q)
         S_LOAD: begin
            fin_d = fin_q | finish;
            if (ovf_s && (!empty_s || push_s)) begin
               state_d  = S_ERR;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               occ_d    = '0;
            end else begin
               if (push_s) begin
                  mem_d[wr_ptr_q] = encode(in_kind, in_rd, in_rs, in_rt, in_shamt, in_aluop, in_imm);
                  wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
               end
               if (pop_s) begin
                  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
                  addr_d   = addr_q + (IMEM_AW+1)'(1);
                  count_d  = count_q + (IMEM_AW+1)'(1);
               end
               occ_d = occ_q + (FIFO_AW+1)'(push_s) - (FIFO_AW+1)'(pop_s);
               // finish may arrive together with the final pop
               if ((fin_q || finish) && (occ_d == '0)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         default: begin
            if (start) begin
               state_d  = S_LOAD;
               addr_d   = (IMEM_AW+1)'(BASE_ADDR);
               count_d  = '0;
               fin_d    = 1'b0;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               occ_d    = '0;
            end else begin
               state_d = state_q;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         addr_q   <= (IMEM_AW+1)'(BASE_ADDR);
         count_q  <= '0;
         fin_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         count_q  <= count_d;
         fin_q    <= fin_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         mem_q    <= mem_d;
      end
   end

endmodule
